// File: rtl/gray_sched.sv
// Round-robin scheduler that lends one shared 3-bit Gray counter to two requesters.
// Each granted job clears the counter, enables it for N cycles, then reports the final value.
module gray_sched #(
  parameter int unsigned STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [STEP_W-1:0] Steps0,
  input  logic [STEP_W-1:0] Steps1,
  input  logic [2:0]        GrayIn,
  input  logic              OvfIn,
  output logic              CntEn,
  output logic              CntClr,
  output logic [1:0]        Gnt,
  output logic [1:0]        Done,
  output logic              Busy,
  output logic [2:0]        LastGray,
  output logic              OvfSeen
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, FINISH} state_t;

  state_t            state, state_next;
  logic              owner, owner_next;
  logic              last_served, last_served_next;
  logic [STEP_W-1:0] remaining, remaining_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      remaining   <= '0;
      LastGray    <= '0;
      OvfSeen     <= 1'b0;
    end else begin
      state       <= state_next;
      owner       <= owner_next;
      last_served <= last_served_next;
      remaining   <= remaining_next;
      // By FINISH the counter has already taken all N steps.
      if (state == FINISH) begin
        LastGray <= GrayIn;
        OvfSeen  <= OvfIn;
      end
    end
  end

  always_comb begin
    state_next       = state;
    owner_next       = owner;
    last_served_next = last_served;
    remaining_next   = remaining;
    CntEn            = 1'b0;
    CntClr           = 1'b0;
    Gnt              = '0;
    Done             = '0;
    Busy             = (state != IDLE);

    unique case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          // On a tie the requester not served last wins.
          owner_next       = (Req0 && Req1) ? ~last_served : Req1;
          last_served_next = owner_next;
          remaining_next   = owner_next ? Steps1 : Steps0;
          state_next       = CLEAR;
        end
      end
      CLEAR: begin
        CntClr     = 1'b1;
        Gnt[owner] = 1'b1;
        state_next = (remaining != '0) ? RUN : FINISH;
      end
      RUN: begin
        CntEn          = 1'b1;
        Gnt[owner]     = 1'b1;
        remaining_next = remaining - 1'b1;
        if (remaining == STEP_W'(1)) state_next = FINISH;
      end
      FINISH: begin
        Done[owner] = 1'b1;
        Gnt[owner]  = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gray_sched.sv
// Self-checking bench for gray_sched: models the shared Gray counter and predicts each
// job's owner, enable length and final Gray/overflow values from the arbitration rules.
module tb_gray_sched;
  localparam int unsigned STEP_W = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Req0, Req1;
  logic [STEP_W-1:0] Steps0, Steps1;
  logic [2:0]        GrayIn;
  logic              OvfIn;
  logic              CntEn, CntClr, Busy, OvfSeen;
  logic [1:0]        Gnt, Done;
  logic [2:0]        LastGray;

  int errors = 0;
  int checks = 0;
  int model_last = 1;

  // Observations of one job, gathered by run_job
  int       o_busy, o_en, o_clr, o_done_n, o_done_c;
  logic [1:0] o_gnt, o_done;
  logic [2:0] o_lg;
  logic       o_ov;
  bit         o_ovl, o_tmo;

  // External counter: binary count shown as Gray, sticky overflow on wrap to zero
  logic [2:0] bcnt;
  logic       ovf;

  gray_sched #(.STEP_W(STEP_W)) dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1),
    .Steps0(Steps0), .Steps1(Steps1), .GrayIn(GrayIn), .OvfIn(OvfIn),
    .CntEn(CntEn), .CntClr(CntClr), .Gnt(Gnt), .Done(Done), .Busy(Busy),
    .LastGray(LastGray), .OvfSeen(OvfSeen)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Reset || CntClr) begin
      bcnt <= 3'd0;
      ovf  <= 1'b0;
    end else if (CntEn) begin
      bcnt <= bcnt + 3'd1;
      if (bcnt == 3'd7) ovf <= 1'b1;
    end
  end
  assign GrayIn = bcnt ^ (bcnt >> 1);
  assign OvfIn  = ovf;

  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) return 1 - model_last;
    return r0 ? 0 : 1;
  endfunction

  function automatic logic [2:0] gray_of(input int n);
    int b = n % 8;
    return 3'(b ^ (b / 2));
  endfunction

  // Drives one request at an IDLE negedge and records what the job did.
  task automatic run_job(input logic r0, input logic r1, input int s0, input int s1,
                         input bit hold, input bit chg, input int chg_val);
    bit seen = 0;
    o_busy = 0; o_en = 0; o_clr = 0; o_done_n = 0; o_done_c = -1;
    o_gnt = '0; o_done = '0; o_lg = '0; o_ov = 1'b0; o_ovl = 0; o_tmo = 1;
    Req0 = r0; Req1 = r1;
    Steps0 = STEP_W'(s0); Steps1 = STEP_W'(s1);
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      if (CntEn) o_en++;
      if (CntClr) o_clr++;
      if (Done != 2'b00) begin o_done_n++; o_done = Done; o_done_c = c; end
      if ((CntEn && CntClr) || (CntEn && Done != 2'b00)) o_ovl = 1;
      if (seen && !Busy) begin
        o_lg = LastGray; o_ov = OvfSeen; o_tmo = 0;
        break;
      end
      if (Busy) begin
        if (!seen) begin seen = 1; o_gnt = Gnt; end
        o_busy++;
        if (!hold) begin Req0 = 1'b0; Req1 = 1'b0; end
        if (chg && c == 2) begin Steps0 = STEP_W'(chg_val); Steps1 = STEP_W'(chg_val); end
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Req0 = 1'b1; Req1 = 1'b1; Steps0 = 4'd5; Steps1 = 4'd3;
    repeat (3) @(negedge Clk);
    checks++;
    if ({CntEn, CntClr, Gnt, Done, Busy, LastGray, OvfSeen} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {CntEn, CntClr, Gnt, Done, Busy, LastGray, OvfSeen});
    end
    Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    model_last = 1;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got=%b exp=0", Busy); end
  endtask

  task automatic test_tie;
    for (int j = 0; j < 3; j++) begin
      int own = pick(1'b1, 1'b1);
      int n = own ? 2 : 3;
      model_last = own;
      run_job(1'b1, 1'b1, 3, 2, 1, 0, 0);
      checks++;
      if (o_tmo || o_gnt !== 2'(1 << own)) begin
        errors++; $display("FAIL tie_gnt job=%0d got=%b exp=%b tmo=%0d", j, o_gnt, 2'(1 << own), o_tmo);
      end
      checks++;
      if (o_lg !== gray_of(n)) begin errors++; $display("FAIL tie_lastgray job=%0d got=%b exp=%b", j, o_lg, gray_of(n)); end
      checks++;
      if (o_done_c !== n + 1 || o_busy !== n + 2) begin
        errors++; $display("FAIL tie_timing job=%0d done_c=%0d busy=%0d exp %0d/%0d", j, o_done_c, o_busy, n + 1, n + 2);
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
  endtask

  task automatic test_single;
    int own = pick(1'b1, 1'b0);
    model_last = own;
    run_job(1'b1, 1'b0, 5, 0, 0, 0, 0);
    checks++; if (o_tmo) begin errors++; $display("FAIL single_timeout got=1 exp=0"); end
    checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", o_gnt); end
    checks++; if (o_clr !== 1) begin errors++; $display("FAIL single_clr got=%0d exp=1", o_clr); end
    checks++; if (o_en !== 5) begin errors++; $display("FAIL single_en got=%0d exp=5", o_en); end
    checks++; if (o_done !== 2'b01 || o_done_n !== 1) begin errors++; $display("FAIL single_done got=%b x%0d exp=01 x1", o_done, o_done_n); end
    checks++; if (o_lg !== 3'b111 || o_ov !== 1'b0) begin errors++; $display("FAIL single_result got=%b/%b exp=111/0", o_lg, o_ov); end
    checks++; if (o_busy !== 7) begin errors++; $display("FAIL single_busy got=%0d exp=7", o_busy); end
    checks++; if (o_ovl) begin errors++; $display("FAIL single_overlap got=1 exp=0"); end
  endtask

  task automatic test_wrap;
    model_last = pick(1'b0, 1'b1);
    run_job(1'b0, 1'b1, 0, 9, 0, 0, 0);
    checks++; if (o_gnt !== 2'b10 || o_done !== 2'b10) begin errors++; $display("FAIL wrap_owner gnt=%b done=%b exp=10", o_gnt, o_done); end
    checks++; if (o_en !== 9) begin errors++; $display("FAIL wrap_en got=%0d exp=9", o_en); end
    checks++; if (o_lg !== 3'b001 || o_ov !== 1'b1) begin errors++; $display("FAIL wrap_result got=%b/%b exp=001/1", o_lg, o_ov); end
    model_last = pick(1'b0, 1'b1);
    run_job(1'b0, 1'b1, 0, 2, 0, 0, 0);
    checks++; if (o_lg !== 3'b011 || o_ov !== 1'b0) begin errors++; $display("FAIL wrap_clear got=%b/%b exp=011/0", o_lg, o_ov); end
  endtask

  task automatic test_zero;
    model_last = pick(1'b1, 1'b0);
    run_job(1'b1, 1'b0, 0, 0, 0, 0, 0);
    checks++; if (o_clr !== 1 || o_en !== 0) begin errors++; $display("FAIL zero_pulses clr=%0d en=%0d exp=1/0", o_clr, o_en); end
    checks++; if (o_done !== 2'b01 || o_done_c !== 1) begin errors++; $display("FAIL zero_done got=%b@%0d exp=01@1", o_done, o_done_c); end
    checks++; if (o_lg !== 3'b000 || o_busy !== 2) begin errors++; $display("FAIL zero_result lg=%b busy=%0d exp=000/2", o_lg, o_busy); end
  endtask

  task automatic test_reset_mid_run;
    int done_seen = 0;
    model_last = pick(1'b1, 1'b0);
    Req0 = 1'b1; Req1 = 1'b0; Steps0 = 4'd10;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      if (c == 0) Req0 = 1'b0;
    end
    checks++; if (CntEn !== 1'b1) begin errors++; $display("FAIL rst_run_pre cnten got=%b exp=1", CntEn); end
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if ({CntEn, CntClr, Gnt, Done, Busy, LastGray, OvfSeen} !== 11'd0) begin
      errors++;
      $display("FAIL rst_run_outputs got=%b exp=0", {CntEn, CntClr, Gnt, Done, Busy, LastGray, OvfSeen});
    end
    Reset = 1'b0;
    model_last = 1;
    repeat (4) begin
      @(negedge Clk);
      if (Done != 2'b00 || Busy) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_run_abandon activity=%0d exp=0", done_seen); end
    model_last = pick(1'b1, 1'b1);
    run_job(1'b1, 1'b1, 2, 6, 0, 0, 0);
    checks++; if (o_gnt !== 2'b01 || o_lg !== 3'b011) begin errors++; $display("FAIL rst_run_tie gnt=%b lg=%b exp=01/011", o_gnt, o_lg); end
  endtask

  task automatic test_drop_steps;
    model_last = pick(1'b1, 1'b0);
    run_job(1'b1, 1'b0, 4, 0, 0, 1, 7);
    checks++; if (o_en !== 4) begin errors++; $display("FAIL drop_en got=%0d exp=4", o_en); end
    checks++; if (o_lg !== 3'b110 || o_done_n !== 1) begin errors++; $display("FAIL drop_result lg=%b done_n=%0d exp=110/1", o_lg, o_done_n); end
    @(negedge Clk);
    checks++; if (Busy !== 1'b0 || Done !== 2'b00) begin errors++; $display("FAIL drop_idle busy=%b done=%b exp=0/00", Busy, Done); end
  endtask

  task automatic test_random;
    for (int j = 0; j < 25; j++) begin
      logic [1:0] r = 2'($urandom_range(1, 3));
      int s0 = int'($urandom_range(0, 15));
      int s1 = int'($urandom_range(0, 15));
      bit hold = bit'($urandom % 2);
      bit chg = bit'($urandom % 2);
      int own = pick(r[0], r[1]);
      int n = own ? s1 : s0;
      model_last = own;
      run_job(r[0], r[1], s0, s1, hold, chg, int'($urandom_range(0, 15)));
      checks++;
      if (o_tmo || o_gnt !== 2'(1 << own) || o_done !== 2'(1 << own) || o_done_n !== 1) begin
        errors++;
        $display("FAIL rand_owner j=%0d gnt=%b done=%b x%0d exp=%b tmo=%0d", j, o_gnt, o_done, o_done_n, 2'(1 << own), o_tmo);
      end
      checks++;
      if (o_en !== n || o_clr !== 1 || o_busy !== n + 2 || o_done_c !== n + 1) begin
        errors++;
        $display("FAIL rand_timing j=%0d en=%0d clr=%0d busy=%0d done_c=%0d exp N=%0d", j, o_en, o_clr, o_busy, o_done_c, n);
      end
      checks++;
      if (o_lg !== gray_of(n) || o_ov !== (n >= 8)) begin
        errors++;
        $display("FAIL rand_result j=%0d got=%b/%b exp=%b/%b", j, o_lg, o_ov, gray_of(n), n >= 8);
      end
      checks++; if (o_ovl) begin errors++; $display("FAIL rand_overlap j=%0d got=1 exp=0", j); end
    end
    Req0 = 1'b0; Req1 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_tie;
    test_single;
    test_wrap;
    test_zero;
    test_reset_mid_run;
    test_drop_steps;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gray_sched.md
# gray_sched

Round-robin scheduler that shares one 3-bit Gray-code counter between two requesters. Each requester asks for a burst of N counter steps. The block grants the counter to one requester, clears it, drives its enable for exactly N cycles, then returns the final Gray value and overflow status with a one-cycle done pulse. It sits between the requesting logic and the `gray` counter instance (`Clk`, `Reset`, `En`, `Output[2:0]`, `Overflow`).

## Interface
- `STEP_W`, default 4: width of the step-count request fields.

- `Clk`  in  1: sole clock, rising edge.
- `Reset`  in  1: synchronous, active-high.
- `Req0`, `Req1`  in  1: per-requester request level.
- `Steps0`, `Steps1`  in  `STEP_W`: step count N, sampled only at grant.
- `GrayIn`  in  3: counter `Output`.
- `OvfIn`  in  1: counter `Overflow`. Sticky in the counter, set when the count wraps to 000.
- `CntEn`  out  1: counter `En`.
- `CntClr`  out  1: one-cycle synchronous clear to the counter.
- `Gnt`  out  2: one-hot current owner.
- `Done`  out  2: one-hot, one-cycle completion pulse.
- `Busy`  out  1: high in any state other than IDLE.
- `LastGray`  out  3: Gray value captured at completion, held until the next completion.
- `OvfSeen`  out  1: overflow captured at completion, held until the next completion.

## Operation
- FSM states: IDLE, CLEAR, RUN, FINISH. All outputs are Moore outputs, decoded from registered state, owner and count.
- **IDLE**
  - `Req0`/`Req1` are sampled only in this state.
  - If only one requester is active, grant it.
  - If both are active, grant the one not served last. The last-served pointer resets to requester 1, so `Req0` wins the first tie.
  - On grant: latch the owner, latch Steps(owner) into the remaining counter, update the last-served pointer, go to CLEAR.
- **CLEAR**
  - Assert `CntClr`=1; `Gnt`[owner]=1.
  - Go to RUN if the latched N≠0, otherwise go to FINISH.
- **RUN**
  - Assert `CntEn`=1 and decrement the remaining counter each cycle.
  - Leave for FINISH after the cycle in which remaining==1, so `CntEn` is high for exactly N consecutive cycles.
- **FINISH**
  - Assert `Done`[owner]=1 and keep `Gnt`[owner]=1.
  - Capture `LastGray`<=`GrayIn` and `OvfSeen`<=`OvfIn`.
  - Go to IDLE.
- Requests and Steps:
  - Dropping `Req` mid-job is ignored; the job completes.
  - A change on `Steps` after grant is ignored.
  - If `Req` is still high in the IDLE cycle after `Done`, it is a new request.
- Arithmetic:
  - The remaining counter is `STEP_W` bits unsigned; N ranges 0..2^`STEP_W`−1.
  - The counter wraps modulo 8, so `LastGray` = gray(N mod 8).
  - `OvfSeen`=1 iff N≥8.
- Reset:
  - `Reset`=1 forces IDLE at the next edge from any state.
  - All outputs reset to 0; `LastGray`=000; pointer resets to requester 1.
  - The in-flight job is abandoned with no `Done`.

## Timing
- Request sampled high in IDLE at edge k:
  - CLEAR runs in cycle k..k+1, with `Gnt` and `Busy` high.
  - The counter clears at edge k+1.
- RUN occupies cycles k+1..k+N, and the counter steps at edges k+2..k+N+1.
- FINISH is the cycle after edge k+N+1:
  - `GrayIn` already reflects N steps.
  - `Done` is high for that cycle; `LastGray`/`OvfSeen` are valid from edge k+N+2.
- Job occupancy:
  - N+2 cycles of `Busy` (CLEAR, N×RUN, FINISH).
  - With N=0: CLEAR then FINISH, 2 cycles, no `CntEn`.
- Minimum turnaround is one IDLE cycle between jobs, so back-to-back jobs start every N+3 cycles.
- `CntEn` and `CntClr` are never high in the same cycle, and `Done` never overlaps `CntEn`.
- `Reset` asserted during RUN: `CntEn` is low from the edge sampling `Reset`.

## Test plan
- **Single job:** `Req0`=1, `Steps0`=5 → `CntClr` pulse, `CntEn` high 5 cycles, `Done`=01, `LastGray`=111 (gray 5), `OvfSeen`=0, `Busy` 7 cycles.
- **Tie round-robin:** `Req0`=`Req1`=1 held through two jobs, `Steps0`=3, `Steps1`=2 → first `Gnt`=01 with `LastGray`=010; after one IDLE cycle `Gnt`=10 with `LastGray`=011; third grant goes to requester 0.
- **Wrap:** `Req1`=1, `Steps1`=9 → `CntEn` high 9 cycles, `LastGray`=001, `OvfSeen`=1; a following job with N=2 gives `OvfSeen`=0, confirming the clear worked.
- **Zero steps:** `Steps0`=0 → `CntClr` for one cycle, `CntEn` never high, `Done`=01 two cycles after the request is sampled, `LastGray`=000.
- **Reset mid-RUN:** `Steps0`=10, assert `Reset` on the 4th RUN cycle → next cycle all outputs 0, no `Done`; after release, `Req0`/`Req1` tie grants requester 0.
- **Request drop and Steps change:** `Req0` pulsed for one IDLE cycle with `Steps0`=4, then `Steps0` changed to 7 during RUN → exactly 4 `CntEn` cycles, `LastGray`=110, a single `Done`, then IDLE.
